// File: rtl/find_first_pkg.sv
// Shared types and helpers for the 2D find-first-set mapping path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package find_first_pkg;

    // Default map geometry. The builder and the scanner both use this shape.
    localparam int MAP_X_W = 7;
    localparam int MAP_Y_W = 5;

    // Index width for an N-entry dimension. The result is never less than 1 bit,
    // so a single-entry dimension still has a port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } builder_state_e;

    // One bitmap row, bit x = column x.
    typedef logic [MAP_X_W-1:0] map_row_t;

endpackage

// File: rtl/idx_to_onehot.sv
// Binary index to one-hot decoder with an in-range flag.
// Latency: combinational.
// Backpressure: none.
// Ports: idx (binary index), onehot (N bits, all zero when out of range), in_range (idx < N).
module idx_to_onehot #(
    parameter int N     = 7,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot,
    output logic             in_range
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

    // Compare one bit wider so that N == 2**IDX_W does not wrap to zero.
    assign in_range = ({1'b0, idx} < (IDX_W+1)'(N));

endmodule

// File: rtl/coord_map_2d_builder.sv
// Collects (X,Y) coordinate beats into a double-buffered bitmap and publishes completed frames.
// Latency: 1 cycle from the accepted last beat to MapValid when the output slot is free.
// Backpressure: CoordReady drops while a closed frame waits for a busy slot (HOLD) or during Abort.
// Ports: ACLK/ARESETn clock and async active-low reset; Coord* is the coordinate stream (valid/ready);
//        Abort discards the working frame; Map* is the output slot (valid/ready) with bitmap, count and error flag.
module coord_map_2d_builder
    import find_first_pkg::*;
#(
    parameter  int DATA_X_W = MAP_X_W,
    parameter  int DATA_Y_W = MAP_Y_W,
    localparam int IDX_X_W  = clog2_min1(DATA_X_W),
    localparam int IDX_Y_W  = clog2_min1(DATA_Y_W),
    localparam int CNT_W    = $clog2(DATA_X_W*DATA_Y_W+1)
) (
    input  logic                               ACLK,
    input  logic                               ARESETn,
    input  logic                               CoordValid,
    output logic                               CoordReady,
    input  logic [IDX_X_W-1:0]                 CoordX,
    input  logic [IDX_Y_W-1:0]                 CoordY,
    input  logic                               CoordLast,
    input  logic                               Abort,
    output logic                               MapValid,
    input  logic                               MapReady,
    output logic [DATA_Y_W-1:0][DATA_X_W-1:0]  MapOut,
    output logic [CNT_W-1:0]                   MapCnt,
    output logic                               MapErr
);

    builder_state_e state, state_nxt;

    logic [DATA_Y_W-1:0][DATA_X_W-1:0] work_map, next_map, wr_mask;
    logic [CNT_W-1:0]                  work_cnt, next_cnt;
    logic                              work_err, next_err;

    logic [DATA_X_W-1:0] onehot_x;
    logic [DATA_Y_W-1:0] onehot_y;
    logic                x_ok, y_ok;
    logic                accept, close, slot_free, transfer, is_new;

    idx_to_onehot #(.N(DATA_X_W), .IDX_W(IDX_X_W)) u_dec_x (
        .idx      (CoordX),
        .onehot   (onehot_x),
        .in_range (x_ok)
    );

    idx_to_onehot #(.N(DATA_Y_W), .IDX_W(IDX_Y_W)) u_dec_y (
        .idx      (CoordY),
        .onehot   (onehot_y),
        .in_range (y_ok)
    );

    assign CoordReady = (state == FILL) && !Abort;
    assign accept     = CoordValid && CoordReady;
    assign close      = accept && CoordLast;
    assign slot_free  = !MapValid || MapReady;

    // Both a fresh close with a free slot and a held frame meeting a consumer
    // handshake load the slot. Abort suppresses the HOLD transfer.
    assign transfer = (close && slot_free) ||
                      ((state == HOLD) && !Abort && MapValid && MapReady);

    always_comb begin
        wr_mask = '0;
        for (int y = 0; y < DATA_Y_W; y++) begin
            wr_mask[y] = onehot_x & {DATA_X_W{onehot_y[y] & accept}};
        end
    end

    // An out-of-range coordinate yields an all-zero mask, so it can never set a bit
    // or bump the count. A duplicate hits an already-set bit and is not counted.
    always_comb begin
        is_new   = |(wr_mask & ~work_map);
        next_map = work_map | wr_mask;
        next_cnt = work_cnt + {{(CNT_W-1){1'b0}}, is_new};
        next_err = work_err | (accept && !(x_ok && y_ok));
    end

    always_comb begin
        state_nxt = state;
        if (Abort) begin
            state_nxt = FILL;
        end else if ((state == FILL) && close && !slot_free) begin
            state_nxt = HOLD;
        end else if ((state == HOLD) && MapValid && MapReady) begin
            state_nxt = FILL;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= FILL;
            work_map <= '0;
            work_cnt <= '0;
            work_err <= 1'b0;
            MapValid <= 1'b0;
            MapOut   <= '0;
            MapCnt   <= '0;
            MapErr   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (transfer) begin
                MapOut   <= next_map;
                MapCnt   <= next_cnt;
                MapErr   <= next_err;
                MapValid <= 1'b1;
                work_map <= '0;
                work_cnt <= '0;
                work_err <= 1'b0;
            end else begin
                if (MapValid && MapReady) begin
                    MapValid <= 1'b0;
                end
                if (Abort) begin
                    work_map <= '0;
                    work_cnt <= '0;
                    work_err <= 1'b0;
                end else if (accept) begin
                    // Includes a close into a busy slot: the merged frame parks here in HOLD.
                    work_map <= next_map;
                    work_cnt <= next_cnt;
                    work_err <= next_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_coord_map_2d_builder.sv
// Directed bench for coord_map_2d_builder (7x5 map).
// Latency: n/a.
// Backpressure: exercised by holding MapReady low.
module tb_coord_map_2d_builder;
    import find_first_pkg::*;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic              CoordValid;
    logic              CoordReady;
    logic [2:0]        CoordX;
    logic [2:0]        CoordY;
    logic              CoordLast;
    logic              Abort;
    logic              MapValid;
    logic              MapReady;
    logic [4:0][6:0]   MapOut;
    logic [5:0]        MapCnt;
    logic              MapErr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ACLK = ~ACLK;

    coord_map_2d_builder #(.DATA_X_W(7), .DATA_Y_W(5)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .CoordValid (CoordValid),
        .CoordReady (CoordReady),
        .CoordX     (CoordX),
        .CoordY     (CoordY),
        .CoordLast  (CoordLast),
        .Abort      (Abort),
        .MapValid   (MapValid),
        .MapReady   (MapReady),
        .MapOut     (MapOut),
        .MapCnt     (MapCnt),
        .MapErr     (MapErr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Builds the packed map from rows y0..y4.
    function automatic logic [34:0] rows(input map_row_t r0, input map_row_t r1, input map_row_t r2,
                                         input map_row_t r3, input map_row_t r4);
        return {r4, r3, r2, r1, r0};
    endfunction

    // Presents one beat for exactly one clock edge; caller leaves time at posedge+1.
    task automatic beat(input int x, input int y, input logic last);
        CoordValid = 1'b1;
        CoordX     = 3'(x);
        CoordY     = 3'(y);
        CoordLast  = last;
        @(posedge ACLK);
        #1;
        CoordValid = 1'b0;
        CoordLast  = 1'b0;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic [34:0] map, input int cnt, input logic err);
        check({tag, ".map"}, 64'(MapOut), 64'(map));
        check({tag, ".cnt"}, 64'(MapCnt), 64'(cnt));
        check({tag, ".err"}, 64'(MapErr), 64'(err));
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        #1;
        check("rst.valid", 64'(MapValid), 64'd0);
        check("rst.map",   64'(MapOut),   64'd0);
        check("rst.cnt",   64'(MapCnt),   64'd0);
        check("rst.ready", 64'(CoordReady), 64'd1);
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
    endtask

    initial begin
        CoordValid = 1'b0;
        CoordX     = '0;
        CoordY     = '0;
        CoordLast  = 1'b0;
        Abort      = 1'b0;
        MapReady   = 1'b1;
        ARESETn    = 1'b1;
        #2;
        do_reset();
        check("rst.err", 64'(MapErr), 64'd0);

        // 1) basic frame
        beat(2, 0, 0); beat(3, 3, 0); beat(1, 2, 0); beat(2, 3, 0);
        check("t1.no_early_valid", 64'(MapValid), 64'd0);
        beat(3, 1, 1);
        check("t1.valid", 64'(MapValid), 64'd1);
        check_slot("t1", rows(7'b0000100, 7'b0001000, 7'b0000010, 7'b0001100, 7'b0000000), 5, 1'b0);
        tick();
        check("t1.consumed", 64'(MapValid), 64'd0);
        check("t1.hold_map", 64'(MapOut),
              64'(rows(7'b0000100, 7'b0001000, 7'b0000010, 7'b0001100, 7'b0000000)));

        // 2) duplicates are idempotent
        beat(4, 4, 0); beat(4, 4, 0); beat(4, 4, 0); beat(0, 0, 1);
        check("t2.valid", 64'(MapValid), 64'd1);
        check_slot("t2", rows(7'b0000001, 7'b0, 7'b0, 7'b0, 7'b0010000), 2, 1'b0);
        tick();

        // 3) busy slot -> HOLD, then transfer on handshake
        MapReady = 1'b0;
        beat(5, 2, 1);
        check_slot("t3a", rows(7'b0, 7'b0, 7'b0100000, 7'b0, 7'b0), 1, 1'b0);
        beat(6, 4, 0); beat(0, 1, 1);
        check("t3.hold_ready", 64'(CoordReady), 64'd0);
        check("t3.hold_valid", 64'(MapValid), 64'd1);
        check("t3.hold_map", 64'(MapOut), 64'(rows(7'b0, 7'b0, 7'b0100000, 7'b0, 7'b0)));
        tick();
        check("t3.still_held", 64'(MapOut), 64'(rows(7'b0, 7'b0, 7'b0100000, 7'b0, 7'b0)));
        MapReady = 1'b1;
        tick();
        MapReady = 1'b0;
        check("t3.valid_b", 64'(MapValid), 64'd1);
        check("t3.ready_b", 64'(CoordReady), 64'd1);
        check_slot("t3b", rows(7'b0, 7'b0000001, 7'b0, 7'b0, 7'b1000000), 2, 1'b0);
        MapReady = 1'b1;
        tick();
        check("t3.drained", 64'(MapValid), 64'd0);

        // 4) out-of-range beat flags error but sets nothing
        beat(7, 0, 0); beat(1, 1, 1);
        check_slot("t4", rows(7'b0, 7'b0000010, 7'b0, 7'b0, 7'b0), 1, 1'b1);
        tick();

        // 5) Abort wins over a concurrent beat and leaves the slot alone
        MapReady = 1'b0;
        beat(2, 2, 1);
        beat(1, 0, 0); beat(2, 0, 0); beat(3, 0, 0);
        Abort      = 1'b1;
        CoordValid = 1'b1;
        CoordX     = 3'd6;
        CoordY     = 3'd3;
        CoordLast  = 1'b1;
        #1;
        check("t5.abort_ready", 64'(CoordReady), 64'd0);
        @(posedge ACLK);
        #1;
        Abort      = 1'b0;
        CoordValid = 1'b0;
        CoordLast  = 1'b0;
        check("t5.slot_valid", 64'(MapValid), 64'd1);
        check_slot("t5a", rows(7'b0, 7'b0, 7'b0000100, 7'b0, 7'b0), 1, 1'b0);
        MapReady = 1'b1;
        beat(0, 4, 1);
        check_slot("t5b", rows(7'b0, 7'b0, 7'b0, 7'b0, 7'b0000001), 1, 1'b0);
        tick();

        // 6a) reset mid-frame
        beat(3, 3, 0); beat(4, 4, 0);
        do_reset();
        beat(1, 0, 1);
        check("t6a.valid", 64'(MapValid), 64'd1);
        check_slot("t6a", rows(7'b0000010, 7'b0, 7'b0, 7'b0, 7'b0), 1, 1'b0);
        tick();

        // 6b) reset while in HOLD
        MapReady = 1'b0;
        beat(0, 0, 1);
        beat(1, 1, 1);
        check("t6b.hold_ready", 64'(CoordReady), 64'd0);
        do_reset();
        MapReady = 1'b1;
        beat(2, 2, 1);
        check_slot("t6b", rows(7'b0, 7'b0, 7'b0000100, 7'b0, 7'b0), 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
